// File: rtl/fsm_learn_pkg.sv
// Shared types and the elaboration-time next-state table builder for fsm_learn.
package fsm_learn_pkg;

  localparam int unsigned MAX_PAT    = 8;
  localparam int unsigned MAX_STATES = MAX_PAT + 1;
  localparam int unsigned STATE_W    = 4;

  // State index Sk: the last k bits received equal the first k bits of the pattern
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S0 = state_t'(0);

  // Indexed as [state][in_bit] -> next state
  typedef logic [MAX_STATES-1:0][1:0][STATE_W-1:0] ns_table_t;

  // Builds the next-state table from the pattern. The pattern's MSB is the first bit received.
  // Each next state is the longest pattern prefix that is a suffix of (matched prefix, in_bit).
  // When overlap is off, the full-match state ignores history and restarts from S0 with the new bit.
  function automatic ns_table_t build_ns_table(input int               pat_len,
                                               input logic [MAX_PAT-1:0] pattern,
                                               input bit               overlap);
    ns_table_t        tbl;
    logic [MAX_PAT:0] seq;
    int               best;
    bit               ok;
    tbl = '0;
    for (int k = 0; k <= pat_len; k++) begin
      for (int b = 0; b < 2; b++) begin
        seq = '0;
        for (int i = 0; i < k; i++) begin
          seq[i] = pattern[pat_len-1-i];
        end
        seq[k] = b[0];
        best   = 0;
        if ((k == pat_len) && !overlap) begin
          best = (b[0] == pattern[pat_len-1]) ? 1 : 0;
        end else begin
          for (int j = 1; (j <= k + 1) && (j <= pat_len); j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
              if (seq[k+1-j+i] != pattern[pat_len-1-i]) begin
                ok = 1'b0;
              end
            end
            if (ok) begin
              best = j;
            end
          end
        end
        tbl[k][b] = STATE_W'(best);
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/fsm_learn_counter.sv
// Saturating match counter. It is built only when FSM_LEARN_COUNT_EN is defined.
module fsm_learn_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] COUNT_MAX = '1;

  // Count on every qualifying edge and hold at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fsm_learn.sv
// Serial pattern detector built as a table-driven Moore FSM.
// The optional macro FSM_LEARN_COUNT_EN adds the det_count port and a saturating match counter.
module fsm_learn
  import fsm_learn_pkg::*;
#(
  parameter int unsigned        PAT_LEN = 2,
  parameter logic [PAT_LEN-1:0] PATTERN = 2'b11,
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_bit,
  output logic        detected
`ifdef FSM_LEARN_COUNT_EN
  ,
  output logic [15:0] det_count
`endif
);

  localparam state_t    S_FULL   = state_t'(PAT_LEN);
  localparam ns_table_t NS_TABLE = build_ns_table(int'(PAT_LEN), MAX_PAT'(PATTERN), OVERLAP);

  state_t state_q;
  state_t state_next;
  logic   detected_next;

  // State register. detected is registered as well, so it mirrors (state_q == S_FULL)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S0;
      detected <= 1'b0;
    end else begin
      state_q  <= state_next;
      detected <= detected_next;
    end
  end

  // Next state comes from the table lookup. Any encoding above S_FULL recovers to S0
  always_comb begin
    state_next = S0;
    if (state_q <= S_FULL) begin
      state_next = NS_TABLE[state_q][in_bit];
    end
  end

  // Full-match decode of the next state. It feeds the detected flop and the counter enable
  always_comb begin
    detected_next = 1'b0;
    if (state_next == S_FULL) begin
      detected_next = 1'b1;
    end
  end

`ifdef FSM_LEARN_COUNT_EN
  fsm_learn_counter #(
    .W(16)
  ) u_counter (
    .clk  (clk),
    .rst_n(reset),
    .inc  (detected_next),
    .count(det_count)
  );
`endif

endmodule

// File: tb/tb_fsm_learn.sv
// Randomized and directed bench for fsm_learn. It uses three instances: the default,
// the non-overlapping form, and a 4-bit pattern 1011. The reference model matches on a
// history of received bits.
module tb_fsm_learn;

  logic clk = 1'b0;
  logic reset;
  logic in_bit;
  logic [2:0] det;
`ifdef FSM_LEARN_COUNT_EN
  logic [2:0][15:0] cnt;
`endif

  always #5 clk = ~clk;

  fsm_learn #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .detected(det[0])
`ifdef FSM_LEARN_COUNT_EN
    , .det_count(cnt[0])
`endif
  );

  fsm_learn #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .detected(det[1])
`ifdef FSM_LEARN_COUNT_EN
    , .det_count(cnt[1])
`endif
  );

  fsm_learn #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut2 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .detected(det[2])
`ifdef FSM_LEARN_COUNT_EN
    , .det_count(cnt[2])
`endif
  );

  // Reference model configuration, one entry per instance
  int unsigned plen [3] = '{2, 2, 4};
  logic [7:0]  pat  [3] = '{8'h03, 8'h03, 8'h0B};
  bit          ovl  [3] = '{1'b1, 1'b0, 1'b1};

  logic [7:0] hist    [3];
  int         avail   [3];
  int         exp_cnt [3];
  logic [2:0] exp_det;

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      hist[d]    = '0;
      avail[d]   = 0;
      exp_cnt[d] = 0;
    end
    exp_det = '0;
  endtask

  // Drive one bit, let one rising edge consume it, then update the model
  task automatic apply_bit(input logic b);
    logic [8:0] m9;
    bit         hit;
    in_bit = b;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      hist[d]  = {hist[d][6:0], b};
      avail[d] = avail[d] + 1;
      m9       = (9'd1 << plen[d]) - 9'd1;
      hit      = (avail[d] >= int'(plen[d])) && ((hist[d] & m9[7:0]) == pat[d]);
      exp_det[d] = hit;
      if (hit) begin
        if (exp_cnt[d] < 65535) exp_cnt[d] = exp_cnt[d] + 1;
        if (!ovl[d]) avail[d] = 0;
      end
    end
  endtask

  // Assert reset partway through the cycle and release it on a falling edge
  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    in_bit = 1'b1;
    model_reset();
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (det[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_initial dut%0d detected=%b expected=0", d, det[d]);
      end
    end
    // Clock edges while reset is held must not advance the FSM
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (det[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_held dut%0d detected=%b expected=0", d, det[d]);
      end
`ifdef FSM_LEARN_COUNT_EN
      checks++;
      if (cnt[d] !== 16'd0) begin
        errors++;
        $display("FAIL reset_count dut%0d det_count=%0d expected=0", d, cnt[d]);
      end
`endif
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    string name;
    int    d;
    string bits;
    string exp;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [6];
    logic b;
    logic e;
    tbl[0] = '{"seq_0011011", 0, "0011011", "0001001"};
    tbl[1] = '{"seq_11011",   0, "11011",   "01001"};
    tbl[2] = '{"seq_1001011", 0, "1001011", "0000001"};
    tbl[3] = '{"ovl_111",     0, "111",     "011"};
    tbl[4] = '{"noovl_111",   1, "111",     "010"};
    tbl[5] = '{"p1011",       2, "1011011", "0001001"};
    for (int t = 0; t < 6; t++) begin
      pulse_reset();
      for (int i = 0; i < tbl[t].bits.len(); i++) begin
        b = (tbl[t].bits[i] == "1");
        e = (tbl[t].exp[i] == "1");
        apply_bit(b);
        checks++;
        if (det[tbl[t].d] !== e) begin
          errors++;
          $display("FAIL %s bit%0d dut%0d detected=%b required=%b",
                   tbl[t].name, i, tbl[t].d, det[tbl[t].d], e);
        end
        for (int d = 0; d < 3; d++) begin
          checks++;
          if (det[d] !== exp_det[d]) begin
            errors++;
            $display("FAIL %s_model bit%0d dut%0d detected=%b model=%b",
                     tbl[t].name, i, d, det[d], exp_det[d]);
          end
        end
      end
`ifdef FSM_LEARN_COUNT_EN
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (cnt[d] !== 16'(exp_cnt[d])) begin
          errors++;
          $display("FAIL %s_count dut%0d det_count=%0d model=%0d",
                   tbl[t].name, d, cnt[d], exp_cnt[d]);
        end
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    apply_bit(1'b1);
    apply_bit(1'b1);
    apply_bit(1'b0);
    apply_bit(1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (det[d] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d detected=%b expected=0", d, det[d]);
      end
`ifdef FSM_LEARN_COUNT_EN
      checks++;
      if (cnt[d] !== 16'd0) begin
        errors++;
        $display("FAIL async_reset_count dut%0d det_count=%0d expected=0", d, cnt[d]);
      end
`endif
    end
    @(negedge clk);
    reset = 1'b1;
    // The partial match is discarded, so a single 1 must not complete "11"
    apply_bit(1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (det[d] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset_no_span dut%0d detected=%b expected=0", d, det[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      apply_bit(1'b1);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (det[d] !== exp_det[d]) begin
          errors++;
          $display("FAIL back_to_back bit%0d dut%0d detected=%b model=%b", i, d, det[d], exp_det[d]);
        end
      end
    end
`ifdef FSM_LEARN_COUNT_EN
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (cnt[d] !== 16'(exp_cnt[d])) begin
        errors++;
        $display("FAIL back_to_back_count dut%0d det_count=%0d model=%0d", d, cnt[d], exp_cnt[d]);
      end
    end
`endif
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
          checks++;
          if (det[d] !== 1'b0) begin
            errors++;
            $display("FAIL random_reset step%0d dut%0d detected=%b expected=0", i, d, det[d]);
          end
        end
        @(negedge clk);
        reset = 1'b1;
      end else begin
        apply_bit(1'($urandom_range(0, 1)));
        for (int d = 0; d < 3; d++) begin
          checks++;
          if (det[d] !== exp_det[d]) begin
            errors++;
            $display("FAIL random step%0d dut%0d detected=%b model=%b", i, d, det[d], exp_det[d]);
          end
`ifdef FSM_LEARN_COUNT_EN
          checks++;
          if (cnt[d] !== 16'(exp_cnt[d])) begin
            errors++;
            $display("FAIL random_count step%0d dut%0d det_count=%0d model=%0d",
                     i, d, cnt[d], exp_cnt[d]);
          end
`endif
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_learn.md
FSM_LEARN -- requirements
Module: fsm_learn

Interface
REQ-001 Parameter PAT_LEN, default 2: pattern length in bits, legal range 1..8.
REQ-002 Parameter PATTERN, default 2'b11, PAT_LEN bits wide: target sequence; the MSB is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = restart after each match.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 Port in_bit, input, 1 bit: serial data, sampled every rising clk edge.
REQ-007 Port detected, output, 1 bit: high while the FSM is in the full-match state.
REQ-008 Port det_count, output, 16 bits: number of completed matches; exists only when FSM_LEARN_COUNT_EN is defined.

Function
REQ-009 The FSM SHALL have PAT_LEN+1 states, S0..S<PAT_LEN>; state Sk means the last k bits received equal the first k bits of PATTERN.
REQ-010 With default parameters, the states SHALL be S0 (idle), S1 (one 1 seen) and S2 (match).
REQ-011 Default transitions: S0 -in0-> S0, S0 -in1-> S1; S1 -in0-> S0, S1 -in1-> S2; S2 -in1-> S2, S2 -in0-> S0.
REQ-012 General next state: the longest proper-or-full prefix of PATTERN that is a suffix of (matched prefix, in_bit).
REQ-013 The next-state table SHALL be computed at elaboration from PATTERN, not hand-coded.
REQ-014 detected SHALL be a Moore output: 1 if and only if state = S<PAT_LEN>, decoded from registered state with no combinational path from in_bit.
REQ-015 Latency: detected rises in the clock cycle immediately after the edge that samples the last pattern bit.
REQ-016 OVERLAP=1: from S<PAT_LEN>, the next state follows the REQ-012 suffix rule; default "111" keeps detected high for two consecutive cycles.
REQ-017 OVERLAP=0: from S<PAT_LEN>, the next state is S1 if in_bit equals PATTERN[MSB], otherwise S0.
REQ-018 There SHALL be no input-valid qualifier; every clk edge consumes one bit.

Reset
REQ-019 reset=0 SHALL force state S0, detected=0 and det_count=0 immediately, independent of clk.
REQ-020 Reset deassertion SHALL be taken synchronously: the first bit is sampled on the first rising edge after reset=1.
REQ-021 A reset asserted in the middle of a sequence SHALL discard the partial match; no detection spans a reset.
REQ-022 Illegal state encodings SHALL return to S0 on the next edge.

Configuration
REQ-023 Macro FSM_LEARN_COUNT_EN defined: det_count SHALL increment by 1 on each edge that enters S<PAT_LEN>, including S<PAT_LEN> -> S<PAT_LEN>.
REQ-024 det_count SHALL saturate at 16'hFFFF.
REQ-025 Macro FSM_LEARN_COUNT_EN undefined: no det_count port and no counter logic exist; all other behaviour is unchanged.

Structure
REQ-026 Package fsm_learn_pkg SHALL hold the state-index typedef (sized for up to 9 states), the S0 constant and the next-state table builder function.
REQ-027 The single sub-module fsm_learn_counter SHALL implement the saturating counter, instantiated only under FSM_LEARN_COUNT_EN.

Verification
REQ-028 Default parameters, reset released, in_bit 0,0,1,1,0,1,1 -> detected high only in the cycles after the 4th and 7th bits.
REQ-029 Pulse reset low for one cycle, then in_bit 1,1,0,1,1 -> detected high after the 2nd and 5th bits; det_count=2.
REQ-030 Pulse reset low, then in_bit 1,0,0,1,0,1,1 -> detected high only after the 7th bit.
REQ-031 in_bit 1,1,1 with OVERLAP=1 -> detected high for 2 cycles, det_count=2; with OVERLAP=0 -> det_count=1.
REQ-032 Assert reset asynchronously while in S1 mid-cycle -> detected=0 at once; a following single 1 does not detect.
REQ-033 PAT_LEN=4, PATTERN=4'b1011, in_bit 1,0,1,1,0,1,1 -> detected after the 4th and 7th bits (overlap).
